fetch_mem_unit: RTL and testbench
=================================

# fetch_mem_unit

- Sits between the unified instruction/data memory and the processor's multi-cycle control unit and datapath.
- Takes one memory command per instruction step (fetch, load or store) and runs a req/ack handshake with a variable-latency memory.
- A fetch result goes into the instruction register, which feeds the control unit's `opcode` and `func` inputs; a load result goes into the memory data register.
- While a transfer is in flight, `busy` is high and the control FSM holds its state. A watchdog aborts any transfer that the memory never acknowledges.

## Interface

Parameters:
- ADDR_W, 12, memory word-address width
- TIMEOUT, 255, max REQ cycles without `mem_ack` before abort (≥2)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cmd  in  2  command from control unit: 00 NONE, 01 FETCH, 10 LOAD, 11 STORE
- adr  in  ADDR_W  address (already muxed by adrsrc)
- wdata  in  16  store data
- err_clr  in  1  clears `err_flag`
- busy  out  1  transfer in progress (control FSM stalls)
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle timeout pulse
- err_flag  out  1  sticky timeout flag
- ir  out  16  instruction register
- opcode  out  4  ir[15:12], to control unit
- func  out  9  ir[8:0], to control unit
- mdr  out  16  memory data register
- mem_req  out  1  request to memory
- mem_we  out  1  write enable (STORE)
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  16  latched store data
- mem_ack  in  1  memory completion; rdata valid in the same cycle
- mem_rdata  in  16  read data

## Operation

- States: IDLE, REQ, DONE, ABORT.
- IDLE:
  - `cmd` is sampled only in IDLE.
  - Non-NONE `cmd` latches `adr`, `wdata` and kind, clears the wait counter and goes to REQ.
  - `cmd` in any other state is ignored; the control unit need not hold it.
- REQ: `mem_req`=1, `mem_we`=(kind==STORE); `mem_addr`/`mem_wdata` come from the latches and stay stable.
  - `mem_ack`=1: on FETCH, ir←`mem_rdata`; on LOAD, mdr←`mem_rdata`; on STORE, no capture. Then go to DONE.
  - No ack: the counter increments. When counter==TIMEOUT-1 with no ack, go to ABORT.
  - Ack and timeout in the same cycle: ack wins and the transfer completes normally.
- DONE: `done`=1 for one cycle, then IDLE.
- ABORT: `err`=1 for one cycle and `err_flag`←1. ir/mdr are unchanged. Then IDLE.
- `err_flag`: held until `err_clr`. If `err_clr` and a new abort coincide, set wins.
- `mem_ack` outside REQ is ignored.
- `busy`=1 in REQ, DONE and ABORT; 0 in IDLE.
- Outputs are decoded from registered state: no combinational path from `cmd` or `mem_ack` to any output.

## Timing

- Reset (rst=0, async): state IDLE; ir, mdr, counter, address/data latches = 0; busy, done, err, err_flag, mem_req, mem_we = 0; opcode=0, func=0.
- Reset mid-transfer: `mem_req` drops immediately and the transfer is abandoned (memory must tolerate this).
- Zero-wait memory (ack in first REQ cycle):
  - cmd accepted at edge 0; REQ in cycle 1; DONE in cycle 2; IDLE in cycle 3.
  - New ir/mdr value is visible in cycle 2, together with `done`.
- N wait cycles: `done` comes N cycles later.
- Back-to-back: the next command is accepted in the IDLE cycle after DONE. Minimum command period is 3 cycles.
- Abort: `err` is asserted TIMEOUT+1 cycles after acceptance.

## Structure

- Shared package `proc_pkg`:
  - cmd encodings CMD_NONE/FETCH/LOAD/STORE
  - state enum
  - instruction field positions OPC_HI/OPC_LO/FUNC_HI/FUNC_LO
- Single module. No sub-module; the watchdog counter is inline.

## Test plan

- Reset: assert rst=0 during a REQ with ir=16'hA1F3 → mem_req=0 at once; ir=0, busy=0, err_flag=0.
- Zero-wait FETCH adr=12'h010, mem_rdata=16'h5123 → done 2 cycles after accept; opcode=4'h5, func=9'h123; mdr unchanged.
- LOAD with 3 wait cycles, rdata=16'hBEEF → mdr=16'hBEEF, busy high 5 cycles; cmd toggled during REQ is ignored.
- STORE adr=12'h3FF, wdata=16'h00C7 → mem_we=1 and mem_wdata=16'h00C7 stable through REQ; ir/mdr untouched.
- TIMEOUT=4, never ack → err pulse 5 cycles after accept; err_flag=1 until err_clr; ir unchanged.
- TIMEOUT=4, ack on the 4th REQ cycle → done, no err. Then issue FETCH in the first IDLE cycle after DONE → accepted.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the processor front end: memory command codes,
// fetch/memory FSM states and instruction-register field positions.
package proc_pkg;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_FETCH = 2'b01;
  localparam logic [1:0] CMD_LOAD  = 2'b10;
  localparam logic [1:0] CMD_STORE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DONE  = 2'd2,
    ST_ABORT = 2'd3
  } state_t;

  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 12;
  localparam int FUNC_HI = 8;
  localparam int FUNC_LO = 0;

endpackage

// File: rtl/fetch_mem_unit.sv
// Memory command sequencer: runs one req/ack transfer per command, captures
// fetched instructions into ir and loaded data into mdr, aborts on timeout.
module fetch_mem_unit
  import proc_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cmd,
  input  logic [ADDR_W-1:0] adr,
  input  logic [15:0]       wdata,
  input  logic              err_clr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              err_flag,
  output logic [15:0]       ir,
  output logic [3:0]        opcode,
  output logic [8:0]        func,
  output logic [15:0]       mdr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            r_state;
  logic [1:0]        r_kind;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_wdata;
  logic [CNT_W-1:0]  r_cnt;
  logic [15:0]       r_ir;
  logic [15:0]       r_mdr;
  logic              r_err_flag;

  logic w_in_req;
  logic w_timeout;

  assign w_in_req  = (r_state == ST_REQ);
  // An ack on the final allowed cycle still completes the transfer.
  assign w_timeout = w_in_req && !mem_ack && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_kind  <= CMD_NONE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_ir    <= '0;
      r_mdr   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd != CMD_NONE) begin
            r_kind  <= cmd;
            r_addr  <= adr;
            r_wdata <= wdata;
            r_cnt   <= '0;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            if (r_kind == CMD_FETCH) r_ir  <= mem_rdata;
            if (r_kind == CMD_LOAD)  r_mdr <= mem_rdata;
            r_state <= ST_DONE;
          end else if (w_timeout) begin
            r_state <= ST_ABORT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Setting covers both the abort edge and the abort cycle, so a clear
  // request overlapping either one loses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_flag <= 1'b0;
    end else if (w_timeout || (r_state == ST_ABORT)) begin
      r_err_flag <= 1'b1;
    end else if (err_clr) begin
      r_err_flag <= 1'b0;
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign err       = (r_state == ST_ABORT);
  assign err_flag  = r_err_flag;
  assign mem_req   = w_in_req;
  assign mem_we    = w_in_req && (r_kind == CMD_STORE);
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign ir        = r_ir;
  assign opcode    = r_ir[OPC_HI:OPC_LO];
  assign func      = r_ir[FUNC_HI:FUNC_LO];
  assign mdr       = r_mdr;

endmodule

// File: tb/tb_fetch_mem_unit.sv
// Scoreboard bench for fetch_mem_unit: directed transfers push expected
// completions; a negedge monitor checks every done/err pulse.
module tb_fetch_mem_unit;
  import proc_pkg::*;

  localparam int TMO = 4;

  logic        clk;
  logic        rst;
  logic [1:0]  cmd;
  logic [11:0] adr;
  logic [15:0] wdata;
  logic        err_clr;
  logic        busy, done, err, err_flag;
  logic [15:0] ir, mdr;
  logic [3:0]  opcode;
  logic [8:0]  func;
  logic        mem_req, mem_we, mem_ack;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;

  fetch_mem_unit #(.ADDR_W(12), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .adr(adr), .wdata(wdata),
    .err_clr(err_clr), .busy(busy), .done(done), .err(err),
    .err_flag(err_flag), .ir(ir), .opcode(opcode), .func(func), .mdr(mdr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {
    bit          is_err;
    int          cyc;
    logic [15:0] ir;
    logic [15:0] mdr;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every done/err pulse must match the oldest expected completion.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst && (done || err)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        chk("pulse_err",  err,  e.is_err);
        chk("pulse_done", done, !e.is_err);
        chk("latency",    cyc,  e.cyc);
        chk("ir",         ir,   e.ir);
        chk("mdr",        mdr,  e.mdr);
        $display("xfer %s at cycle %0d ir=%h mdr=%h", err ? "abort" : "done", cyc, ir, mdr);
      end
    end
  end

  // Called at #1 into an IDLE cycle; returns at #1 into the following IDLE cycle.
  task automatic xfer(input logic [1:0] k, input logic [11:0] a, input logic [15:0] wd,
                      input int waits, input bit ack, input logic [15:0] rd,
                      input logic [15:0] eir, input logic [15:0] emdr,
                      input bit toggle, input bit clr_in_abort);
    exp_t e;
    int   acc;
    int   nreq;
    cmd = k; adr = a; wdata = wd;
    @(posedge clk); #1;
    acc = cyc;
    cmd = toggle ? CMD_STORE : CMD_NONE;
    adr = ~a; wdata = ~wd;
    e.is_err = !ack;
    e.cyc    = ack ? acc + 1 + waits : acc + TMO;
    e.ir     = eir;
    e.mdr    = emdr;
    sb.push_back(e);
    nreq = ack ? waits : TMO;
    for (int i = 0; i < nreq; i++) begin
      chk("req_mem_req",   mem_req,   1'b1);
      chk("req_busy",      busy,      1'b1);
      chk("req_mem_addr",  mem_addr,  a);
      chk("req_mem_we",    mem_we,    k == CMD_STORE);
      chk("req_mem_wdata", mem_wdata, wd);
      if (toggle) cmd = (i % 2) ? CMD_FETCH : CMD_LOAD;
      @(posedge clk); #1;
    end
    if (ack) begin
      chk("ack_mem_req", mem_req, 1'b1);
      mem_ack = 1'b1; mem_rdata = rd;
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = 16'hDEAD;
    end else if (clr_in_abort) begin
      err_clr = 1'b1;
    end
    chk("end_busy",    busy,    1'b1);
    chk("end_mem_req", mem_req, 1'b0);
    @(posedge clk); #1;
    err_clr = 1'b0; cmd = CMD_NONE;
    chk("idle_busy", busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; cmd = CMD_NONE; adr = '0; wdata = '0; err_clr = 1'b0;
    mem_ack = 1'b0; mem_rdata = 16'hDEAD;
    #12;
    chk("rst_busy",     busy,     1'b0);
    chk("rst_mem_req",  mem_req,  1'b0);
    chk("rst_err_flag", err_flag, 1'b0);
    chk("rst_ir",       ir,       16'h0);
    chk("rst_mdr",      mdr,      16'h0);
    chk("rst_mem_addr", mem_addr, 12'h0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;

    xfer(CMD_FETCH, 12'h010, 16'h0000, 0, 1'b1, 16'h5123, 16'h5123, 16'h0000, 1'b0, 1'b0);
    chk("opcode", opcode, 4'h5);
    chk("func",   func,   9'h123);

    xfer(CMD_LOAD,  12'h020, 16'h0000, 3, 1'b1, 16'hBEEF, 16'h5123, 16'hBEEF, 1'b1, 1'b0);
    xfer(CMD_STORE, 12'h3FF, 16'h00C7, 1, 1'b1, 16'h7777, 16'h5123, 16'hBEEF, 1'b0, 1'b0);

    xfer(CMD_FETCH, 12'h123, 16'h0000, 0, 1'b0, 16'h0000, 16'h5123, 16'hBEEF, 1'b0, 1'b0);
    chk("flag_set", err_flag, 1'b1);
    @(posedge clk); #1; @(posedge clk); #1;
    chk("flag_held", err_flag, 1'b1);
    err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    chk("flag_cleared", err_flag, 1'b0);

    xfer(CMD_LOAD, 12'h0AA, 16'h0000, 0, 1'b0, 16'h0000, 16'h5123, 16'hBEEF, 1'b0, 1'b1);
    chk("flag_set_wins", err_flag, 1'b1);

    xfer(CMD_LOAD,  12'h044, 16'h0000, TMO - 1, 1'b1, 16'h1234, 16'h5123, 16'h1234, 1'b0, 1'b0);
    xfer(CMD_FETCH, 12'h045, 16'h0000, 0, 1'b1, 16'hA1F3, 16'hA1F3, 16'h1234, 1'b0, 1'b0);

    mem_ack = 1'b1; mem_rdata = 16'hFFFF;
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = 16'hDEAD;
    chk("idle_ack_busy", busy, 1'b0);
    chk("idle_ack_ir",   ir,   16'hA1F3);
    chk("idle_ack_mdr",  mdr,  16'h1234);

    cmd = CMD_FETCH; adr = 12'h050;
    @(posedge clk); #1; cmd = CMD_NONE;
    chk("pre_rst_mem_req", mem_req, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_mem_req",  mem_req,  1'b0);
    chk("midrst_ir",       ir,       16'h0);
    chk("midrst_busy",     busy,     1'b0);
    chk("midrst_err_flag", err_flag, 1'b0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; @(posedge clk); #1;
    chk("post_rst_busy", busy, 1'b0);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
